// File: rtl/match_controller.sv
// Match sequencer for a two-player fighting game: intro countdown, timed rounds,
// post-round hold and best-of-N scoring, all driven from a shared game tick.
module match_controller #(
    parameter int TICK_MAX      = 100_000_000,
    parameter int ROUND_TIME    = 99,
    parameter int INTRO_TICKS   = 3,
    parameter int HOLD_TICKS    = 3,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_rst_n,
    output logic       round_over,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [6:0] round_timer,
    output logic [2:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] match_winner
);

    // state      | meaning
    // IDLE       | waiting for start, game core held in reset
    // INTRO      | pre-fight countdown, game core held in reset
    // FIGHT      | round running, round timer counting down
    // ROUND_END  | round scored, health frozen for display
    // MATCH_END  | winner shown until the next start press

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INTRO     = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_MATCH_END = 3'd4
    } state_t;

    localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [1:0]    CD_INIT    = 2'(INTRO_TICKS);
    localparam logic [6:0]    TIMER_INIT = 7'(ROUND_TIME);
    localparam logic [2:0]    RN_MAX     = 3'(MAX_ROUNDS);
    localparam logic [1:0]    WIN_ROUNDS = 2'(ROUNDS_TO_WIN);

    state_t          cur_state;
    state_t          nxt_state;
    logic [TW-1:0]   tick_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            start_prev;
    logic            start_armed;
    logic            tick;
    logic            start_rise;
    logic            state_change;

    logic            nxt_game_rst_n;
    logic            nxt_round_over;
    logic [1:0]      nxt_countdown;
    logic [6:0]      nxt_round_timer;
    logic [2:0]      nxt_round_num;
    logic [1:0]      nxt_p1_rounds;
    logic [1:0]      nxt_p2_rounds;
    logic [1:0]      nxt_match_winner;
    logic [HW-1:0]   nxt_hold_cnt;

    function automatic logic [1:0] inc_sat(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign tick         = (tick_cnt == TICK_LAST);
    // start_armed blocks a press that was already held when reset released
    assign start_rise   = start && !start_prev && start_armed;
    assign state_change = (nxt_state != cur_state);
    assign state        = cur_state;

    always_comb begin
        nxt_state        = cur_state;
        nxt_countdown    = countdown;
        nxt_round_timer  = round_timer;
        nxt_round_num    = round_num;
        nxt_p1_rounds    = p1_rounds;
        nxt_p2_rounds    = p2_rounds;
        nxt_match_winner = match_winner;
        nxt_hold_cnt     = hold_cnt;

        case (cur_state)
            ST_IDLE, ST_MATCH_END: begin
                if (start_rise) begin
                    nxt_state        = ST_INTRO;
                    nxt_p1_rounds    = 2'd0;
                    nxt_p2_rounds    = 2'd0;
                    nxt_round_num    = 3'd1;
                    nxt_match_winner = 2'b00;
                    nxt_countdown    = CD_INIT;
                end
            end
            ST_INTRO: begin
                if (tick) begin
                    if (countdown == 2'd1) begin
                        nxt_state       = ST_FIGHT;
                        nxt_countdown   = 2'd0;
                        nxt_round_timer = TIMER_INIT;
                    end else begin
                        nxt_countdown = countdown - 2'd1;
                    end
                end
            end
            ST_FIGHT: begin
                if (tick && round_timer != 7'd0)
                    nxt_round_timer = round_timer - 7'd1;
                // a KO reported on the timeout tick outranks the health comparison
                if (finish == 2'b01) begin
                    nxt_state     = ST_ROUND_END;
                    nxt_p1_rounds = inc_sat(p1_rounds);
                end else if (finish == 2'b11) begin
                    nxt_state     = ST_ROUND_END;
                    nxt_p2_rounds = inc_sat(p2_rounds);
                end else if (tick && round_timer == 7'd1) begin
                    nxt_state = ST_ROUND_END;
                    if (p1_health > p2_health)
                        nxt_p1_rounds = inc_sat(p1_rounds);
                    else if (p2_health > p1_health)
                        nxt_p2_rounds = inc_sat(p2_rounds);
                end
            end
            ST_ROUND_END: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (p1_rounds == WIN_ROUNDS || p2_rounds == WIN_ROUNDS ||
                            round_num == RN_MAX) begin
                            nxt_state = ST_MATCH_END;
                            if (p1_rounds > p2_rounds)
                                nxt_match_winner = 2'b01;
                            else if (p1_rounds < p2_rounds)
                                nxt_match_winner = 2'b11;
                            else
                                nxt_match_winner = 2'b10;
                        end else begin
                            nxt_state     = ST_INTRO;
                            nxt_countdown = CD_INIT;
                            nxt_round_num = (round_num >= RN_MAX) ? round_num
                                                                  : round_num + 3'd1;
                        end
                    end else begin
                        nxt_hold_cnt = hold_cnt + HW'(1);
                    end
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        nxt_game_rst_n = (nxt_state == ST_FIGHT) || (nxt_state == ST_ROUND_END) ||
                         (nxt_state == ST_MATCH_END);
        nxt_round_over = (nxt_state == ST_ROUND_END) || (nxt_state == ST_MATCH_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= ST_IDLE;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            start_prev   <= 1'b0;
            start_armed  <= 1'b0;
            game_rst_n   <= 1'b0;
            round_over   <= 1'b0;
            countdown    <= 2'd0;
            round_timer  <= 7'd0;
            round_num    <= 3'd0;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            match_winner <= 2'b00;
        end else begin
            cur_state    <= nxt_state;
            start_prev   <= start;
            if (!start)
                start_armed <= 1'b1;
            if (state_change || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);
            hold_cnt     <= state_change ? '0 : nxt_hold_cnt;
            game_rst_n   <= nxt_game_rst_n;
            round_over   <= nxt_round_over;
            countdown    <= nxt_countdown;
            round_timer  <= nxt_round_timer;
            round_num    <= nxt_round_num;
            p1_rounds    <= nxt_p1_rounds;
            p2_rounds    <= nxt_p2_rounds;
            match_winner <= nxt_match_winner;
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: a table of input/expected-output steps
// walking three full matches, plus hand sequences for async reset and start arming.
module tb_match_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] finish;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic       game_rst_n;
    logic       round_over;
    logic [2:0] state;
    logic [1:0] countdown;
    logic [6:0] round_timer;
    logic [2:0] round_num;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] match_winner;

    int checks = 0;
    int errors = 0;

    match_controller #(
        .TICK_MAX(4), .ROUND_TIME(5), .INTRO_TICKS(3),
        .HOLD_TICKS(2), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_rst_n(game_rst_n), .round_over(round_over), .state(state),
        .countdown(countdown), .round_timer(round_timer), .round_num(round_num),
        .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .match_winner(match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       st;
        logic [1:0] fin;
        logic [3:0] h1;
        logic [3:0] h2;
        logic [22:0] exp;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs[NV];

    function automatic logic [22:0] pack(input int s, input int cd, input int t,
                                         input int rn, input int r1, input int r2,
                                         input int w, input int grn, input int ro);
        logic [22:0] p;
        p = {3'(s), 2'(cd), 7'(t), 3'(rn), 2'(r1), 2'(r2), 2'(w), 1'(grn), 1'(ro)};
        return p;
    endfunction

    function automatic vec_t mk(input int cyc, input int st, input int fin,
                                input int h1, input int h2,
                                input int s, input int cd, input int t, input int rn,
                                input int r1, input int r2, input int w,
                                input int grn, input int ro);
        vec_t v;
        v.cyc = cyc;
        v.st  = 1'(st);
        v.fin = 2'(fin);
        v.h1  = 4'(h1);
        v.h2  = 4'(h2);
        v.exp = pack(s, cd, t, rn, r1, r2, w, grn, ro);
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = {state, countdown, round_timer, round_num, p1_rounds, p2_rounds,
               match_winner, game_rst_n, round_over};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got st=%0d cd=%0d tmr=%0d rn=%0d p1=%0d p2=%0d win=%0d grn=%0d ro=%0d | want st=%0d cd=%0d tmr=%0d rn=%0d p1=%0d p2=%0d win=%0d grn=%0d ro=%0d",
                     name, act[22:20], act[19:18], act[17:11], act[10:8], act[7:6],
                     act[5:4], act[3:2], act[1], act[0], exp[22:20], exp[19:18],
                     exp[17:11], exp[10:8], exp[7:6], exp[5:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // match 1: P1 KO, P2 on timeout health, P2 KO on the timeout tick
        vecs[0]  = mk( 1,1,0, 0,0,  1,3,0,1,0,0,0,0,0);
        vecs[1]  = mk( 4,0,0, 0,0,  1,2,0,1,0,0,0,0,0);
        vecs[2]  = mk( 4,0,0, 0,0,  1,1,0,1,0,0,0,0,0);
        vecs[3]  = mk( 3,0,0, 0,0,  1,1,0,1,0,0,0,0,0);
        vecs[4]  = mk( 1,0,0, 0,0,  2,0,5,1,0,0,0,1,0);
        vecs[5]  = mk( 1,0,1, 0,0,  3,0,5,1,1,0,0,1,1);
        vecs[6]  = mk( 7,0,0, 0,0,  3,0,5,1,1,0,0,1,1);
        vecs[7]  = mk( 1,0,0, 0,0,  1,3,5,2,1,0,0,0,0);
        vecs[8]  = mk(12,0,0, 7,9,  2,0,5,2,1,0,0,1,0);
        vecs[9]  = mk( 4,0,0, 7,9,  2,0,4,2,1,0,0,1,0);
        vecs[10] = mk(15,0,0, 7,9,  2,0,1,2,1,0,0,1,0);
        vecs[11] = mk( 1,0,0, 7,9,  3,0,0,2,1,1,0,1,1);
        vecs[12] = mk( 8,0,0, 7,9,  1,3,0,3,1,1,0,0,0);
        vecs[13] = mk(12,0,0,15,0,  2,0,5,3,1,1,0,1,0);
        vecs[14] = mk(19,0,0,15,0,  2,0,1,3,1,1,0,1,0);
        vecs[15] = mk( 1,0,3,15,0,  3,0,0,3,1,2,0,1,1);
        vecs[16] = mk( 7,0,0,15,0,  3,0,0,3,1,2,0,1,1);
        vecs[17] = mk( 1,0,0,15,0,  4,0,0,3,1,2,3,1,1);
        vecs[18] = mk( 3,0,0,15,0,  4,0,0,3,1,2,3,1,1);
        // match 2: P1 wins two KOs; finish=10 ignored, finish in ROUND_END ignored
        vecs[19] = mk( 1,1,0, 0,0,  1,3,0,1,0,0,0,0,0);
        vecs[20] = mk(12,0,0, 0,0,  2,0,5,1,0,0,0,1,0);
        vecs[21] = mk( 2,0,1, 0,0,  3,0,5,1,1,0,0,1,1);
        vecs[22] = mk( 7,0,0, 0,0,  1,3,5,2,1,0,0,0,0);
        vecs[23] = mk(12,0,0, 0,0,  2,0,5,2,1,0,0,1,0);
        vecs[24] = mk( 3,0,2, 0,0,  2,0,5,2,1,0,0,1,0);
        vecs[25] = mk( 1,0,1, 0,0,  3,0,4,2,2,0,0,1,1);
        vecs[26] = mk( 8,0,0, 0,0,  4,0,4,2,2,0,1,1,1);
        // match 3: three equal-health timeouts end in a draw at the round cap
        vecs[27] = mk( 1,1,0, 5,5,  1,3,4,1,0,0,0,0,0);
        vecs[28] = mk(12,0,0, 5,5,  2,0,5,1,0,0,0,1,0);
        vecs[29] = mk(20,0,0, 5,5,  3,0,0,1,0,0,0,1,1);
        vecs[30] = mk( 8,0,0, 5,5,  1,3,0,2,0,0,0,0,0);
        vecs[31] = mk(32,0,0, 5,5,  3,0,0,2,0,0,0,1,1);
        vecs[32] = mk( 8,0,0, 5,5,  1,3,0,3,0,0,0,0,0);
        vecs[33] = mk(32,0,0, 5,5,  3,0,0,3,0,0,0,1,1);
        vecs[34] = mk( 8,0,0, 5,5,  4,0,0,3,0,0,2,1,1);
        vecs[35] = mk( 1,1,0, 5,5,  1,3,0,1,0,0,0,0,0);
        vecs[36] = mk( 1,1,0, 5,5,  1,3,0,1,0,0,0,0,0);

        reset = 1'b1;
        start = 1'b0;
        finish = 2'b00;
        p1_health = 4'd0;
        p2_health = 4'd0;
        step(3);
        check("reset_state", pack(0,0,0,0,0,0,0,0,0));
        #2 reset = 1'b0;
        step(2);
        check("idle_after_reset", pack(0,0,0,0,0,0,0,0,0));

        for (int i = 0; i < NV; i++) begin
            start     = vecs[i].st;
            finish    = vecs[i].fin;
            p1_health = vecs[i].h1;
            p2_health = vecs[i].h2;
            step(vecs[i].cyc);
            check($sformatf("row%0d", i), vecs[i].exp);
        end

        // async reset mid-FIGHT, observed before the next clock edge
        start = 1'b0;
        step(11);
        check("fight_before_reset", pack(2,0,5,1,0,0,0,1,0));
        step(2);
        #3 reset = 1'b1;
        #1;
        check("async_reset_no_edge", pack(0,0,0,0,0,0,0,0,0));
        start = 1'b1;
        step(2);
        check("reset_held", pack(0,0,0,0,0,0,0,0,0));
        #2 reset = 1'b0;
        step(4);
        check("start_held_through_reset", pack(0,0,0,0,0,0,0,0,0));
        start = 1'b0;
        step(1);
        check("start_released", pack(0,0,0,0,0,0,0,0,0));
        start = 1'b1;
        step(1);
        check("start_after_rearm", pack(1,3,0,1,0,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
